// File: rtl/uart_rx_link.sv
// 8N1 serial receiver with 16x oversampling, a one-entry holding register
// (valid/ack toward the consumer) and registered framing-error / overrun pulses.
module uart_rx_link #(
    parameter int DIV       = 163,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ack,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    localparam logic [15:0] TICK_MAX = 16'(DIV - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [15:0]          r_tick_cnt;
    logic                 w_tick;
    logic [2:0]           r_state;
    logic [3:0]           r_os_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 w_stop_sample;
    logic                 w_complete;
    logic                 w_frame_bad;

    // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Free-running oversample divider; the FSM never restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    assign w_tick = (r_tick_cnt == TICK_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state  <= S_START;
                        r_os_cnt <= '0;
                    end
                end
                S_START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (r_os_cnt == 4'd7) begin
                        r_os_cnt  <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                end
                S_DATA: begin
                    if (r_os_cnt == 4'd15) begin
                        r_os_cnt <= '0;
                        r_shreg  <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                end
                S_STOP: begin
                    if (r_os_cnt == 4'd15) begin
                        r_os_cnt <= '0;
                        r_state  <= r_rx_s ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        r_os_cnt <= r_os_cnt + 4'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_stop_sample = w_tick && (r_state == S_STOP) && (r_os_cnt == 4'd15);
    assign w_complete    = w_stop_sample && r_rx_s;
    assign w_frame_bad   = w_stop_sample && !r_rx_s;

    // Holding register: a same-clock ack frees the slot for the byte completing now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= w_frame_bad;
            overrun   <= w_complete && dout_valid && !dout_ack;
            if (w_complete && (!dout_valid || dout_ack)) begin
                dout       <= r_shreg;
                dout_valid <= 1'b1;
            end else if (dout_ack && dout_valid) begin
                dout_valid <= 1'b0;
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_link.sv
// Bench for uart_rx_link at DIV=4: table-driven frames, hand-written corner
// sequences and a randomized run checked against a holding-register model.
module tb_uart_rx_link;

    localparam int DIV     = 4;
    localparam int BIT_CLK = 16 * DIV;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_dout;
        int         exp_ferr;
    } vec_t;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       rx       = 1'b1;
    logic       dout_ack = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [2:0] dbg_state;

    int         errors    = 0;
    int         checks    = 0;
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         both_cnt  = 0;
    logic [7:0] exp_q[$];
    vec_t       tbl[6];

    uart_rx_link #(.DIV(DIV), .DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ack   (dout_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (frame_err && overrun) both_cnt++;
    end

    initial begin
        #(600000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called on a negedge; drives one 8N1 frame. A zero stop bit holds the line low 200 clk.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CLK) @(negedge clk);
        if (!stop) begin
            repeat (200 - BIT_CLK) @(negedge clk);
            rx = 1'b1;
            repeat (32) @(negedge clk);
        end
    endtask

    // Sends a good frame and returns clocks from start edge to dout_valid seen (-1 if never).
    task automatic send_measure(input logic [7:0] b, output int lat);
        int l;
        l = -1;
        fork
            send_frame(b, 1'b1);
            begin
                for (int n = 1; n <= 700; n++) begin
                    @(negedge clk);
                    if (dout_valid) begin
                        l = n;
                        break;
                    end
                end
            end
        join
        lat = l;
    endtask

    task automatic do_ack();
        dout_ack = 1'b1;
        @(negedge clk);
        dout_ack = 1'b0;
    endtask

    initial begin
        int         lat;
        int         f0;
        int         o0;
        logic       busy_seen;
        logic       hold;
        logic       good;
        logic [7:0] b;
        int         exp_ovr;

        tbl[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        tbl[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        tbl[2] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        tbl[3] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
        tbl[4] = '{8'h55, 1'b0, 1'b0, 8'h00, 1};
        tbl[5] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 0};

        // Reset takes effect without a clock edge.
        #2 reset = 1'b0;
        #1;
        check("reset_dout", int'(dout), 0);
        check("reset_valid", int'(dout_valid), 0);
        check("reset_ferr", int'(frame_err), 0);
        check("reset_ovr", int'(overrun), 0);
        check("reset_busy", int'(busy), 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // 0xA5 latency window and ack.
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_measure(8'hA5, lat);
        check("a5_latency_608_614", int'(lat >= 608 && lat <= 614), 1);
        check("a5_dout", int'(dout), 'hA5);
        check("a5_valid", int'(dout_valid), 1);
        check("a5_ferr", ferr_cnt - f0, 0);
        check("a5_ovr", ovr_cnt - o0, 0);
        do_ack();
        check("a5_ack_clears_valid", int'(dout_valid), 0);
        repeat (20) @(negedge clk);

        // Short low glitch: start rejected, no flags.
        f0 = ferr_cnt; o0 = ovr_cnt;
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("glitch_busy_seen", int'(busy_seen), 1);
        check("glitch_busy_end", int'(busy), 0);
        check("glitch_valid", int'(dout_valid), 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_ovr", ovr_cnt - o0, 0);

        // Bad stop with long low line, then a clean frame.
        f0 = ferr_cnt;
        fork
            send_frame(8'h3C, 1'b0);
            begin
                repeat (9 * BIT_CLK + 190) @(negedge clk);
                check("break_busy_while_low", int'(busy), 1);
            end
        join
        check("break_single_ferr", ferr_cnt - f0, 1);
        check("break_valid", int'(dout_valid), 0);
        check("break_busy_after_high", int'(busy), 0);
        send_frame(8'h5A, 1'b1);
        check("after_break_dout", int'(dout), 'h5A);
        check("after_break_valid", int'(dout_valid), 1);
        do_ack();
        repeat (10) @(negedge clk);

        // Table-driven frames, each acked when valid.
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_cnt;
            send_frame(tbl[i].data, tbl[i].stop);
            check($sformatf("tbl%0d_valid", i), int'(dout_valid), int'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) check($sformatf("tbl%0d_dout", i), int'(dout), int'(tbl[i].exp_dout));
            check($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].exp_ferr);
            if (dout_valid) do_ack();
            repeat (5) @(negedge clk);
        end

        // Overrun: second byte dropped while the first is unacked.
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr_dout_kept", int'(dout), 'h11);
        check("ovr_valid", int'(dout_valid), 1);
        check("ovr_pulse_count", ovr_cnt - o0, 1);
        check("ovr_no_ferr", ferr_cnt - f0, 0);
        do_ack();
        check("ovr_ack_clears", int'(dout_valid), 0);
        send_frame(8'h33, 1'b1);
        check("ovr_next_dout", int'(dout), 'h33);
        do_ack();
        repeat (10) @(negedge clk);

        // Ack on the exact clock the second back-to-back frame completes.
        o0 = ovr_cnt;
        send_measure(8'h80, lat);
        check("b2b_first_latency", int'(lat >= 608 && lat <= 614), 1);
        check("b2b_first_dout", int'(dout), 'h80);
        fork
            send_frame(8'h01, 1'b1);
            begin
                repeat (lat - 1) @(negedge clk);
                dout_ack = 1'b1;
                @(negedge clk);
                dout_ack = 1'b0;
                check("b2b_valid_at_complete", int'(dout_valid), 1);
                check("b2b_dout_at_complete", int'(dout), 'h01);
            end
        join
        check("b2b_dout", int'(dout), 'h01);
        check("b2b_valid", int'(dout_valid), 1);
        check("b2b_no_ovr", ovr_cnt - o0, 0);

        // Reset in the middle of a 0xFF frame while a byte is held.
        rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx = 1'b1;
        repeat (150) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1;
        check("midreset_dout", int'(dout), 0);
        check("midreset_valid", int'(dout_valid), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ferr", int'(frame_err), 0);
        check("midreset_ovr", int'(overrun), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        send_frame(8'h7E, 1'b1);
        check("post_reset_dout", int'(dout), 'h7E);
        check("post_reset_valid", int'(dout_valid), 1);
        do_ack();
        repeat (10) @(negedge clk);

        // Randomized frames against a one-entry holding-register model.
        hold = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            f0 = ferr_cnt; o0 = ovr_cnt;
            send_frame(b, good);
            exp_ovr = 0;
            if (good) begin
                if (!hold) begin
                    exp_q.push_back(b);
                    hold = 1'b1;
                end else begin
                    exp_ovr = 1;
                end
            end
            check($sformatf("rnd%0d_valid", i), int'(dout_valid), int'(hold));
            check($sformatf("rnd%0d_ferr", i), ferr_cnt - f0, int'(!good));
            check($sformatf("rnd%0d_ovr", i), ovr_cnt - o0, exp_ovr);
            if ($urandom_range(0, 1) != 0) begin
                if (hold) check($sformatf("rnd%0d_dout", i), int'(dout), int'(exp_q.pop_front()));
                do_ack();
                hold = 1'b0;
                check($sformatf("rnd%0d_after_ack", i), int'(dout_valid), 0);
            end
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        if (hold) begin
            check("rnd_final_dout", int'(dout), int'(exp_q.pop_front()));
            do_ack();
        end

        check("ferr_ovr_never_together", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
